sdio_cmd_seq: RTL and testbench
===============================

SDIO_CMD_SEQ -- requirements
Module: sdio_cmd_seq

Interface
REQ-001 Parameter RSP_TIMEOUT, default 64, meaning max bit-times waited for response start bit.
REQ-002 clk_i  in  1  system clock.
REQ-003 rstn_i  in  1  reset, asynchronous, active-low.
REQ-004 sdclk_en_i  in  1  one-cycle strobe marking each SD bit-time; all bit operations occur only on strobe cycles.
REQ-005 cmd_start_i  in  1  request pulse; cmd_index_i  in  6  command index; cmd_arg_i  in  32  argument.
REQ-006 rsp_type_i  in  2  0 none, 1 R48 with CRC, 2 R48 no CRC, 3 R136.
REQ-007 busy_o  out  1  sequence active; done_o  out  1  one-cycle completion pulse.
REQ-008 rsp_timeout_o  out  1  sticky until next start; rsp_crc_err_o  out  1  sticky until next start.
REQ-009 rsp_o  out  128  received response payload.
REQ-010 cmd_o  out  1  CMD line drive; cmd_oe_o  out  1  CMD output enable, active high; cmd_i  in  1  CMD line sample.
REQ-011 crc_data_o, crc_sample_o, crc_clr_o, crc_shift_o  out  1 each  CRC7 engine controls; crc_serial_i  in  1  engine MSB; crc_i  in  7  engine register.

Function
REQ-012 States: IDLE, TX_BITS, TX_CRC, TX_END, WAIT_RSP, RX_BITS, RX_CHECK, DONE.
REQ-013 IDLE: cmd_start_i latches index/arg/type, pulses crc_clr_o one cycle, clears sticky errors, sets busy_o, enters TX_BITS; cmd_start_i while busy_o=1 is ignored.
REQ-014 TX_BITS: on 40 strobes drives frame bits 47..8 (0, 1, index, arg MSB first) with cmd_oe_o=1, crc_data_o=bit, crc_sample_o=1 same cycle.
REQ-015 TX_CRC: on 7 strobes drives cmd_o=crc_serial_i and pulses crc_shift_o; TX_END drives cmd_o=1 for one strobe.
REQ-016 cmd_o, cmd_oe_o registered: change in cycle after the strobe; idle values cmd_o=1, cmd_oe_o=0.
REQ-017 After TX_END: type 0 -> DONE; else cmd_oe_o=0, crc_clr_o pulse, WAIT_RSP.
REQ-018 WAIT_RSP: cmd_i=0 on strobe is start bit (sampled into CRC) -> RX_BITS; RSP_TIMEOUT strobes without it -> rsp_timeout_o=1, DONE.
REQ-019 RX_BITS: R48 receives 47 more bits, CRC-sampling frame bits 46..8; R136 receives 135 more bits, no CRC sampling.
REQ-020 rsp_o: R48 -> rsp_o[37:32]=index field, [31:0]=arg field, [127:38]=0; R136 -> frame bits 127..0.
REQ-021 RX_CHECK (one cycle): type 1 sets rsp_crc_err_o if crc_i differs from received bits 7..1; types 1,2,3 set it if end bit is 0.
REQ-022 DONE: done_o=1 one cycle, busy_o=0 next cycle, return IDLE.
REQ-023 Never asserts more than one of crc_sample_o/crc_clr_o/crc_shift_o in a cycle; all zero outside listed cases.
REQ-024 Bit counter 8 bits, saturating not required; timeout counter width clog2(RSP_TIMEOUT+1).

Reset
REQ-025 Reset (any state) -> IDLE, busy_o=0, done_o=0, errors=0, rsp_o=0, cmd_o=1, cmd_oe_o=0, all CRC controls 0.

Configuration
REQ-026 SDIO_CMD_RSP_CRC_CHECK_EN defined: REQ-021 CRC compare active for type 1.
REQ-027 Undefined: no CRC sampling during receive, type 1 treated as type 2, rsp_crc_err_o reflects end-bit only.

Verification
REQ-028 CMD0 arg 0x00000000 type 0 -> CMD line 0x400000000095 MSB first, done_o, no errors.
REQ-029 CMD8 arg 0x000001AA -> line 0x48000001AA87; response 0x08000001AA87 injected -> rsp_o[37:0]=0x08000001AA, no error.
REQ-030 Same response with CRC 0x44 -> rsp_crc_err_o=1 (macro defined), 0 (undefined).
REQ-031 CMD17 type 1, cmd_i held 1 -> rsp_timeout_o=1, done_o exactly 64 strobes after TX_END.
REQ-032 rstn_i low during TX_BITS bit 20 -> cmd_oe_o=0, cmd_o=1, busy_o=0 immediately; new start after release sends full frame.
REQ-033 cmd_start_i pulsed while busy -> ignored, frame in progress unchanged.

Source files
------------

// File: rtl/sdio_cmd_seq.sv
// rtl/sdio_cmd_seq.sv - SD/SDIO CMD-line command/response sequencer driving an external CRC7 engine.
// Optional receive CRC compare is enabled by defining SDIO_CMD_RSP_CRC_CHECK_EN.
module sdio_cmd_seq #(
    parameter int RSP_TIMEOUT = 64
) (
    input  logic         clk_i,
    input  logic         rstn_i,
    input  logic         sdclk_en_i,
    input  logic         cmd_start_i,
    input  logic [5:0]   cmd_index_i,
    input  logic [31:0]  cmd_arg_i,
    input  logic [1:0]   rsp_type_i,
    output logic         busy_o,
    output logic         done_o,
    output logic         rsp_timeout_o,
    output logic         rsp_crc_err_o,
    output logic [127:0] rsp_o,
    output logic         cmd_o,
    output logic         cmd_oe_o,
    input  logic         cmd_i,
    output logic         crc_data_o,
    output logic         crc_sample_o,
    output logic         crc_clr_o,
    output logic         crc_shift_o,
    input  logic         crc_serial_i,
    input  logic [6:0]   crc_i
);

    localparam int TO_W = $clog2(RSP_TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE, TX_BITS, TX_CRC, TX_END, WAIT_RSP, RX_BITS, RX_CHECK, DONE
    } state_t;

    state_t          state;
    logic [39:0]     tx_sr;
    logic [1:0]      rsp_type;
    logic [7:0]      bit_cnt;
    logic [TO_W-1:0] to_cnt;
    logic            stb;
    logic            rx_crc_en;
    logic            crc_chk;

`ifdef SDIO_CMD_RSP_CRC_CHECK_EN
    assign rx_crc_en = (rsp_type != 2'd3);
    assign crc_chk   = (rsp_type == 2'd1);
`else
    assign rx_crc_en = 1'b0;
    assign crc_chk   = 1'b0;
`endif

    // A strobe landing on the CRC clear cycle is deferred so the engine never sees clear and sample together.
    assign stb = sdclk_en_i & ~crc_clr_o;

    always_comb begin
        crc_sample_o = 1'b0;
        crc_shift_o  = 1'b0;
        crc_data_o   = 1'b0;
        if (stb) begin
            case (state)
                TX_BITS: begin
                    crc_sample_o = 1'b1;
                    crc_data_o   = tx_sr[39];
                end
                TX_CRC: crc_shift_o = 1'b1;
                WAIT_RSP: begin
                    crc_sample_o = rx_crc_en & ~cmd_i;
                    crc_data_o   = 1'b0;
                end
                RX_BITS: begin
                    crc_sample_o = rx_crc_en & (bit_cnt >= 8'd8);
                    crc_data_o   = crc_sample_o & cmd_i;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state         <= IDLE;
            tx_sr         <= '0;
            rsp_type      <= '0;
            bit_cnt       <= '0;
            to_cnt        <= '0;
            busy_o        <= 1'b0;
            done_o        <= 1'b0;
            rsp_timeout_o <= 1'b0;
            rsp_crc_err_o <= 1'b0;
            rsp_o         <= '0;
            cmd_o         <= 1'b1;
            cmd_oe_o      <= 1'b0;
            crc_clr_o     <= 1'b0;
        end else begin
            done_o    <= 1'b0;
            crc_clr_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_start_i) begin
                        tx_sr         <= {2'b01, cmd_index_i, cmd_arg_i};
                        rsp_type      <= rsp_type_i;
                        crc_clr_o     <= 1'b1;
                        rsp_timeout_o <= 1'b0;
                        rsp_crc_err_o <= 1'b0;
                        busy_o        <= 1'b1;
                        bit_cnt       <= 8'd39;
                        state         <= TX_BITS;
                    end
                end
                TX_BITS: begin
                    if (stb) begin
                        cmd_o    <= tx_sr[39];
                        cmd_oe_o <= 1'b1;
                        tx_sr    <= {tx_sr[38:0], 1'b0};
                        if (bit_cnt == 8'd0) begin
                            bit_cnt <= 8'd6;
                            state   <= TX_CRC;
                        end else begin
                            bit_cnt <= bit_cnt - 8'd1;
                        end
                    end
                end
                TX_CRC: begin
                    if (stb) begin
                        cmd_o <= crc_serial_i;
                        if (bit_cnt == 8'd0) state <= TX_END;
                        else bit_cnt <= bit_cnt - 8'd1;
                    end
                end
                TX_END: begin
                    if (stb) begin
                        cmd_o <= 1'b1;
                        if (rsp_type == 2'd0) begin
                            done_o <= 1'b1;
                            state  <= DONE;
                        end else begin
                            crc_clr_o <= 1'b1;
                            to_cnt    <= '0;
                            state     <= WAIT_RSP;
                        end
                    end
                end
                WAIT_RSP: begin
                    // The end bit stays driven for one full bit-time before the line is released.
                    if (stb) begin
                        cmd_oe_o <= 1'b0;
                        if (!cmd_i) begin
                            bit_cnt <= (rsp_type == 2'd3) ? 8'd134 : 8'd46;
                            state   <= RX_BITS;
                        end else if (to_cnt == TO_W'(RSP_TIMEOUT - 1)) begin
                            rsp_timeout_o <= 1'b1;
                            done_o        <= 1'b1;
                            state         <= DONE;
                        end else begin
                            to_cnt <= to_cnt + 1'b1;
                        end
                    end
                end
                RX_BITS: begin
                    if (stb) begin
                        rsp_o <= {rsp_o[126:0], cmd_i};
                        if (bit_cnt == 8'd0) state <= RX_CHECK;
                        else bit_cnt <= bit_cnt - 8'd1;
                    end
                end
                RX_CHECK: begin
                    // R48 arrives with bits 46..0 in rsp_o[46:0]; keep only index and argument.
                    if (rsp_type != 2'd3) rsp_o <= {90'd0, rsp_o[45:8]};
                    if (!rsp_o[0] || (crc_chk && (crc_i != rsp_o[7:1]))) rsp_crc_err_o <= 1'b1;
                    done_o <= 1'b1;
                    state  <= DONE;
                end
                DONE: begin
                    busy_o   <= 1'b0;
                    cmd_o    <= 1'b1;
                    cmd_oe_o <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sdio_cmd_seq.sv
// tb/tb_sdio_cmd_seq.sv - directed self-checking bench for sdio_cmd_seq with a CRC7 engine model.
module tb_sdio_cmd_seq;

    logic         clk = 1'b0;
    logic         rstn = 1'b0;
    logic         cmd_start = 1'b0;
    logic [5:0]   cmd_index = '0;
    logic [31:0]  cmd_arg = '0;
    logic [1:0]   rsp_type = '0;
    logic         busy, done, rsp_timeout, rsp_crc_err;
    logic [127:0] rsp;
    logic         cmd_out, cmd_oe;
    logic         cmd_in = 1'b1;
    logic         crc_data, crc_sample, crc_clr, crc_shift;
    logic [6:0]   crc = '0;
    logic [1:0]   phase = '0;
    logic         sdclk_en;
    logic         en_q = 1'b0;

    int checks = 0;
    int failures = 0;
    logic [47:0] line;
    int cap_cnt, done_cnt, done_at, stb_cnt;
    int ovl_cnt = 0;

    sdio_cmd_seq #(.RSP_TIMEOUT(64)) dut (
        .clk_i(clk), .rstn_i(rstn), .sdclk_en_i(sdclk_en),
        .cmd_start_i(cmd_start), .cmd_index_i(cmd_index), .cmd_arg_i(cmd_arg),
        .rsp_type_i(rsp_type), .busy_o(busy), .done_o(done),
        .rsp_timeout_o(rsp_timeout), .rsp_crc_err_o(rsp_crc_err), .rsp_o(rsp),
        .cmd_o(cmd_out), .cmd_oe_o(cmd_oe), .cmd_i(cmd_in),
        .crc_data_o(crc_data), .crc_sample_o(crc_sample), .crc_clr_o(crc_clr),
        .crc_shift_o(crc_shift), .crc_serial_i(crc[6]), .crc_i(crc)
    );

    always #5 clk = ~clk;

    // SD bit-time strobe: one cycle in four.
    always @(negedge clk) phase <= phase + 2'd1;
    assign sdclk_en = (phase == 2'd0);

    // External CRC7 engine, x^7 + x^3 + 1.
    always @(posedge clk) begin
        if (crc_clr) crc <= 7'd0;
        else if (crc_sample) crc <= {crc[5:0], 1'b0} ^ ((crc_data ^ crc[6]) ? 7'h09 : 7'h00);
        else if (crc_shift) crc <= {crc[5:0], 1'b0};
        if (int'(crc_clr) + int'(crc_sample) + int'(crc_shift) > 1) ovl_cnt++;
        en_q <= sdclk_en;
    end

    always @(negedge clk) begin
        if (en_q) begin
            if (busy) stb_cnt++;
            if (cmd_oe) begin
                line = {line[46:0], cmd_out};
                cap_cnt++;
            end
        end
        if (done) begin
            done_cnt++;
            done_at = stb_cnt;
        end
    end

    task automatic drive_bit(input logic b);
        do begin
            @(negedge clk);
            #1;
        end while (phase != 2'd0);
        cmd_in = b;
    endtask

    task automatic clear_obs();
        line = '0;
        cap_cnt = 0;
        done_cnt = 0;
        done_at = -1;
        stb_cnt = 0;
    endtask

    task automatic start_cmd(input logic [5:0] idx, input logic [31:0] arg, input logic [1:0] typ);
        clear_obs();
        cmd_index = idx;
        cmd_arg = arg;
        rsp_type = typ;
        do begin
            @(negedge clk);
            #1;
        end while (phase != 2'd1);
        cmd_start = 1'b1;
        @(negedge clk);
        #1;
        cmd_start = 1'b0;
    endtask

    task automatic run_cmd(input logic [5:0] idx, input logic [31:0] arg, input logic [1:0] typ,
                           input logic [135:0] rbits, input int rlen, input bit poke);
        start_cmd(idx, arg, typ);
        if (poke) begin
            repeat (10) drive_bit(1'b1);
            cmd_index = 6'h3F;
            cmd_arg = 32'hFFFF_FFFF;
            rsp_type = 2'd0;
            cmd_start = 1'b1;
            @(negedge clk);
            #1;
            cmd_start = 1'b0;
        end
        if (rlen > 0) begin
            repeat (poke ? 39 : 49) drive_bit(1'b1);
            for (int i = rlen - 1; i >= 0; i--) drive_bit(rbits[i]);
            drive_bit(1'b1);
        end
        for (int i = 0; i < 4000 && done_cnt == 0; i++) @(negedge clk);
        checks++;
        if (done_cnt == 0) begin
            failures++;
            $display("FAIL done_wait: done_o never seen for CMD%0d", idx);
        end
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (done_cnt !== 1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL done_pulse: done_cnt=%0d busy=%b, required 1 and 0", done_cnt, busy);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if ({busy, done, rsp_timeout, rsp_crc_err, cmd_out, cmd_oe} !== 6'b000010) begin
            failures++;
            $display("FAIL reset_outs: busy,done,to,err,cmd,oe=%b required 000010",
                     {busy, done, rsp_timeout, rsp_crc_err, cmd_out, cmd_oe});
        end
        checks++;
        if (rsp !== 128'd0 || {crc_data, crc_sample, crc_clr, crc_shift} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_rsp_crc: rsp=%h crc_ctl=%b required 0", rsp,
                     {crc_data, crc_sample, crc_clr, crc_shift});
        end
        rstn = 1'b1;
    endtask

    task automatic test_cmd0();
        run_cmd(6'd0, 32'h0, 2'd0, '0, 0, 1'b0);
        checks++;
        if (line !== 48'h400000000095 || cap_cnt != 48) begin
            failures++;
            $display("FAIL cmd0_line: line=%h bits=%0d required 400000000095 48", line, cap_cnt);
        end
        checks++;
        if (done_at != 48 || rsp_timeout !== 1'b0 || rsp_crc_err !== 1'b0) begin
            failures++;
            $display("FAIL cmd0_done: at strobe %0d to=%b err=%b required 48 0 0", done_at, rsp_timeout, rsp_crc_err);
        end
    endtask

    task automatic test_cmd8();
        run_cmd(6'd8, 32'h0000_01AA, 2'd1, {88'd0, 48'h08000001AA87}, 48, 1'b0);
        checks++;
        if (line !== 48'h48000001AA87) begin
            failures++;
            $display("FAIL cmd8_line: line=%h required 48000001aa87", line);
        end
        checks++;
        if (rsp !== {90'd0, 38'h08000001AA}) begin
            failures++;
            $display("FAIL cmd8_rsp: rsp=%h required 08000001aa", rsp);
        end
        checks++;
        if (rsp_crc_err !== 1'b0 || rsp_timeout !== 1'b0) begin
            failures++;
            $display("FAIL cmd8_err: err=%b to=%b required 0 0", rsp_crc_err, rsp_timeout);
        end
    endtask

    task automatic test_bad_crc();
        logic exp_err;
`ifdef SDIO_CMD_RSP_CRC_CHECK_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif
        run_cmd(6'd8, 32'h0000_01AA, 2'd1, {88'd0, 48'h08000001AA89}, 48, 1'b0);
        checks++;
        if (rsp_crc_err !== exp_err) begin
            failures++;
            $display("FAIL bad_crc: err=%b required %b", rsp_crc_err, exp_err);
        end
        run_cmd(6'd8, 32'h0000_01AA, 2'd2, {88'd0, 48'h08000001AA86}, 48, 1'b0);
        checks++;
        if (rsp_crc_err !== 1'b1) begin
            failures++;
            $display("FAIL end_bit: err=%b required 1", rsp_crc_err);
        end
    endtask

    task automatic test_timeout();
        run_cmd(6'd17, 32'h0000_0200, 2'd1, '0, 0, 1'b0);
        checks++;
        if (rsp_timeout !== 1'b1 || done_at != 112) begin
            failures++;
            $display("FAIL timeout: to=%b done at strobe %0d required 1 112", rsp_timeout, done_at);
        end
        checks++;
        if (line !== 48'h510000020067 - 48'h0 && line[47:8] !== 40'h5100000200) begin
            failures++;
            $display("FAIL cmd17_line: line=%h required 5100000200xx", line);
        end
    endtask

    task automatic test_r136();
        logic [127:0] exp;
        exp = 128'h0123456789ABCDEFFEDCBA9876543211;
        run_cmd(6'd2, 32'h0, 2'd3, {8'h3F, exp}, 136, 1'b0);
        checks++;
        if (rsp !== exp || rsp_crc_err !== 1'b0 || rsp_timeout !== 1'b0) begin
            failures++;
            $display("FAIL r136: rsp=%h err=%b to=%b required %h 0 0", rsp, rsp_crc_err, rsp_timeout, exp);
        end
    endtask

    task automatic test_reset_mid();
        start_cmd(6'd17, 32'h0, 2'd1);
        repeat (28) drive_bit(1'b1);
        @(negedge clk);
        rstn = 1'b0;
        #1;
        checks++;
        if ({cmd_oe, cmd_out, busy} !== 3'b010) begin
            failures++;
            $display("FAIL reset_mid: oe,cmd,busy=%b required 010", {cmd_oe, cmd_out, busy});
        end
        @(negedge clk);
        rstn = 1'b1;
        test_cmd0();
    endtask

    task automatic test_back_to_back();
        run_cmd(6'd8, 32'h0000_01AA, 2'd1, {88'd0, 48'h08000001AA87}, 48, 1'b1);
        checks++;
        if (line !== 48'h48000001AA87 || rsp !== {90'd0, 38'h08000001AA}) begin
            failures++;
            $display("FAIL busy_start: line=%h rsp=%h required 48000001aa87 08000001aa", line, rsp);
        end
    endtask

    initial begin
        test_reset();
        test_cmd0();
        test_cmd8();
        test_bad_crc();
        test_timeout();
        test_r136();
        test_reset_mid();
        test_back_to_back();
        checks++;
        if (ovl_cnt != 0) begin
            failures++;
            $display("FAIL crc_ctl_overlap: %0d cycles with multiple controls, required 0", ovl_cnt);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
